// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-side and response signals of the shared-ALU issue controller.
// slave = controller view, master = environment (requesters, ALU, consumer).
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int BITS  = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [BITS-1:0]  req0_op;
  logic             req0_cin;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [BITS-1:0]  req1_op;
  logic             req1_cin;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [BITS-1:0]  alu_opcode;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_result;
  logic             alu_s;
  logic             alu_z;
  logic             alu_c;
  logic             alu_v;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_result;
  logic [3:0]       resp_flags;
  logic             resp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, req1_cin,
    output req1_ready,
    output alu_a, alu_b, alu_opcode, alu_cin,
    input  alu_result, alu_s, alu_z, alu_c, alu_v,
    output resp_valid, resp_id, resp_result, resp_flags, resp_err,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op, req1_cin,
    input  req1_ready,
    input  alu_a, alu_b, alu_opcode, alu_cin,
    output alu_result, alu_s, alu_z, alu_c, alu_v,
    input  resp_valid, resp_id, resp_result, resp_flags, resp_err,
    output resp_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Round-robin issue of two requesters onto one combinational ALU, one op in flight.
// Accept -> response after lat+1 cycles (error ops after 1); held in DONE until resp_ready.
module alu_issue_ctrl #(
  parameter int WIDTH   = 16,
  parameter int BITS    = 4,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.slave   bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [BITS-1:0] OP_MULT = BITS'(2);
  localparam logic [BITS-1:0] OP_DIV  = BITS'(3);
  localparam logic [BITS-1:0] OP_MAX  = BITS'(11);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [BITS-1:0]  r_op;
  logic             r_cin;
  logic             r_id;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_err;

  logic             w_gnt_vld;
  logic             w_gnt_id;
  logic             w_accept;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [BITS-1:0]  w_op;
  logic             w_cin;
  logic             w_div_zero;
  logic             w_illegal;
  logic             w_err;
  logic [CW-1:0]    w_cnt_init;

  // Tie goes to the requester that did not win last; a lone requester always wins.
  always_comb begin
    w_gnt_vld = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      w_gnt_id = ~r_last_grant;
    end else begin
      w_gnt_id = ~bus.req0_valid;
    end
    w_a        = w_gnt_id ? bus.req1_a   : bus.req0_a;
    w_b        = w_gnt_id ? bus.req1_b   : bus.req0_b;
    w_op       = w_gnt_id ? bus.req1_op  : bus.req0_op;
    w_cin      = w_gnt_id ? bus.req1_cin : bus.req0_cin;
    w_accept   = (r_state == S_IDLE) && w_gnt_vld;
    w_div_zero = (w_op == OP_DIV) && (w_b == '0);
    w_illegal  = (w_op > OP_MAX);
    w_err      = w_div_zero | w_illegal;
    if (w_op == OP_MULT) begin
      w_cnt_init = CW'(MUL_LAT - 1);
    end else if (w_op == OP_DIV) begin
      w_cnt_init = CW'(DIV_LAT - 1);
    end else begin
      w_cnt_init = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    bus.req0_ready  = w_accept && !w_gnt_id;
    bus.req1_ready  = w_accept && w_gnt_id;
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.alu_opcode  = '0;
    bus.alu_cin     = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_id     = 1'b0;
    bus.resp_result = '0;
    bus.resp_flags  = '0;
    bus.resp_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_err ? S_DONE : S_EXEC;
        end
      end
      S_EXEC: begin
        bus.alu_a      = r_a;
        bus.alu_b      = r_b;
        bus.alu_opcode = r_op;
        bus.alu_cin    = r_cin;
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        bus.resp_valid  = 1'b1;
        bus.resp_id     = r_id;
        bus.resp_result = r_result;
        bus.resp_flags  = r_flags;
        bus.resp_err    = r_err;
        if (bus.resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_cin        <= 1'b0;
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_result     <= '0;
      r_flags      <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a          <= w_a;
            r_b          <= w_b;
            r_op         <= w_op;
            r_cin        <= w_cin;
            r_id         <= w_gnt_id;
            r_last_grant <= w_gnt_id;
            r_cnt        <= w_cnt_init;
            r_flags      <= '0;
            r_err        <= w_err;
            // Error ops skip the ALU: saturated quotient for /0, zero for bad opcode.
            r_result     <= w_div_zero ? '1 : '0;
          end
        end
        S_EXEC: begin
          if (r_cnt == '0) begin
            r_result <= bus.alu_result;
            r_flags  <= {bus.alu_s, bus.alu_z, bus.alu_c, bus.alu_v};
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
